intr_ctrl: RTL and testbench

- Prioritised interrupt controller sitting between the peripheral interrupt sources (UART RX/TX, future timers/switch debouncers) and the single INTERRUPT input of the 16-bit tramelblaze core.
- Latches request edges into a pending register and applies a software-written enable mask.
- Drives one interrupt line through an assert/acknowledge/service handshake.
- Presents the winning source ID on a read port, so the ISR can dispatch and then clear that source.

---
 rtl/intr_ctrl.sv | 133 +++++++++++++
 tb/tb_intr_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller: edge-latched pending bits, enable mask,
// single interrupt line with assert/acknowledge/service handshake and an ID port.
module intr_ctrl #(
    parameter int unsigned NSRC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
    input  logic            en_wr,
    input  logic [7:0]      data_in,
    input  logic            id_rd,
    input  logic            ack,
    output logic            intr,
    output logic [7:0]      id_out,
    output logic [NSRC-1:0] pend_out,
    output logic [NSRC-1:0] en_out
);

    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NSRC-1:0]   pending;
    logic [NSRC-1:0]   enable;
    logic [NSRC-1:0]   irq_prev;
    logic [NSRC-1:0]   rise_c;
    logic [NSRC-1:0]   eligible_c;
    logic [NSRC-1:0]   clr_mask_c;
    logic              any_elig_c;
    logic [IDX_W-1:0]  win_idx_c;
    logic [IDX_W-1:0]  index;
    logic [IDX_W-1:0]  index_nxt;
    logic              intr_nxt;
    logic              clr_c;
    logic [7:0]        id_nxt;
    logic              data_unused_c;

    // Upper data_in bits are only meaningful when NSRC is 8.
    assign data_unused_c = ^data_in;

    assign rise_c     = irq_in & ~irq_prev;
    assign eligible_c = pending & enable;
    assign any_elig_c = |eligible_c;
    assign clr_mask_c = clr_c ? (NSRC'(1) << index) : '0;

    assign pend_out = pending;
    assign en_out   = enable;

    // Lowest-numbered eligible source wins.
    always_comb begin
        win_idx_c = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (eligible_c[i]) begin
                win_idx_c = IDX_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ack beats an eligible drop in REQ.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_elig_c) state_nxt = REQ;
            REQ: begin
                if (ack) begin
                    state_nxt = SERVICE;
                end else if (!any_elig_c) begin
                    state_nxt = IDLE;
                end
            end
            SERVICE: if (id_rd) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/datapath next values, registered below.
    always_comb begin
        intr_nxt  = 1'b0;
        index_nxt = index;
        clr_c     = 1'b0;
        case (state)
            IDLE: intr_nxt = any_elig_c;
            REQ: begin
                if (ack) begin
                    index_nxt = win_idx_c;
                end else begin
                    intr_nxt = any_elig_c;
                end
            end
            SERVICE: clr_c = id_rd;
            default: ;
        endcase
        id_nxt = (state_nxt == SERVICE) ? {1'b1, 4'b0000, index_nxt} : 8'h00;
    end

    // Registered outputs, pending/enable registers and edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intr     <= 1'b0;
            index    <= '0;
            id_out   <= 8'h00;
            pending  <= '0;
            enable   <= '1;
            irq_prev <= '0;
        end else begin
            intr     <= intr_nxt;
            index    <= index_nxt;
            id_out   <= id_nxt;
            // A new rise wins over a same-cycle clear.
            pending  <= (pending & ~clr_mask_c) | rise_c;
            irq_prev <= irq_in;
            if (en_wr) begin
                enable <= data_in[NSRC-1:0];
            end
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: expected IDs are queued at ack and checked when SERVICE shows them.
module tb_intr_ctrl;

    localparam int unsigned NSRC = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NSRC-1:0] irq_in = '0;
    logic            en_wr = 1'b0;
    logic [7:0]      data_in = 8'h00;
    logic            id_rd = 1'b0;
    logic            ack = 1'b0;
    logic            intr;
    logic [7:0]      id_out;
    logic [NSRC-1:0] pend_out;
    logic [NSRC-1:0] en_out;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [7:0]  exp_q[$];
    int unsigned high_cnt;

    intr_ctrl #(.NSRC(NSRC)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .en_wr    (en_wr),
        .data_in  (data_in),
        .id_rd    (id_rd),
        .ack      (ack),
        .intr     (intr),
        .id_out   (id_out),
        .pend_out (pend_out),
        .en_out   (en_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_intr(input string tag);
        for (int i = 0; i < 20 && intr !== 1'b1; i++) tick();
        check(tag, 32'(intr), 32'd1);
    endtask

    // Ack now (REQ assumed), expect exp_id in SERVICE, then id_rd immediately.
    task automatic service(input string tag, input logic [7:0] exp_id);
        ack = 1'b1;
        exp_q.push_back(exp_id);
        tick();
        ack = 1'b0;
        check({tag, "_intr_lo"}, 32'(intr), 32'd0);
        if (exp_q.size() != 0) check({tag, "_id"}, 32'(id_out), 32'(exp_q.pop_front()));
        id_rd = 1'b1;
        tick();
        id_rd = 1'b0;
        check({tag, "_id_clr"}, 32'(id_out), 32'd0);
    endtask

    task automatic write_en(input logic [7:0] val);
        en_wr   = 1'b1;
        data_in = val;
        tick();
        en_wr   = 1'b0;
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        tick();
        check("rst_pend", 32'(pend_out), 32'h0);
        check("rst_en", 32'(en_out), 32'hF);
        check("rst_id", 32'(id_out), 32'h00);
        check("rst_intr", 32'(intr), 32'd0);
        rst = 1'b0;
        tick();

        // Single event on source 2; cycle T is the pulse cycle.
        irq_in = 4'b0100;
        tick();
        irq_in = 4'b0000;
        check("single_pend", 32'(pend_out), 32'h4);
        check("single_intr_t1", 32'(intr), 32'd0);
        tick();
        check("single_intr_t2", 32'(intr), 32'd1);
        tick(); tick(); tick();
        check("single_intr_held", 32'(intr), 32'd1);
        ack = 1'b1;
        exp_q.push_back(8'h82);
        tick();
        ack = 1'b0;
        check("single_intr_lo", 32'(intr), 32'd0);
        check("single_id", 32'(id_out), 32'(exp_q.pop_front()));
        tick();
        id_rd = 1'b1;
        tick();
        id_rd = 1'b0;
        check("single_pend_clr", 32'(pend_out), 32'h0);
        check("single_id_clr", 32'(id_out), 32'h00);
        // id_rd outside SERVICE is inert.
        id_rd = 1'b1;
        tick();
        id_rd = 1'b0;
        check("idrd_idle_id", 32'(id_out), 32'h00);
        check("idrd_idle_intr", 32'(intr), 32'd0);

        // Priority: sources 3 and 1 rise together.
        irq_in = 4'b1010;
        tick();
        irq_in = 4'b0000;
        check("pri_pend", 32'(pend_out), 32'hA);
        wait_intr("pri_wait1");
        service("pri1", 8'h81);
        check("pri_gap_idle", 32'(intr), 32'd0);
        tick();
        check("pri_gap_req", 32'(intr), 32'd1);
        service("pri2", 8'h83);
        check("pri_pend_clr", 32'(pend_out), 32'h0);

        // Masking: pending sets regardless of enable.
        write_en(8'h0E);
        check("mask_en", 32'(en_out), 32'hE);
        irq_in = 4'b0001;
        tick();
        irq_in = 4'b0000;
        check("mask_pend", 32'(pend_out), 32'h1);
        tick(); tick();
        check("mask_intr_off", 32'(intr), 32'd0);
        write_en(8'hFF);
        check("unmask_en", 32'(en_out), 32'hF);
        check("unmask_intr_edge", 32'(intr), 32'd0);
        tick();
        check("unmask_intr", 32'(intr), 32'd1);
        service("unmask", 8'h80);

        // Mask the only eligible source while in REQ.
        irq_in = 4'b1000;
        tick();
        irq_in = 4'b0000;
        tick();
        check("reqmask_intr", 32'(intr), 32'd1);
        write_en(8'h07);
        tick();
        check("reqmask_intr_fall", 32'(intr), 32'd0);
        check("reqmask_pend", 32'(pend_out), 32'h8);
        write_en(8'h0F);
        wait_intr("reqmask_wait");
        service("reqmask", 8'h83);

        // Set/clear collision on source 1.
        irq_in = 4'b0010;
        tick();
        irq_in = 4'b0000;
        wait_intr("coll_wait");
        ack = 1'b1;
        exp_q.push_back(8'h81);
        tick();
        ack = 1'b0;
        check("coll_id", 32'(id_out), 32'(exp_q.pop_front()));
        id_rd  = 1'b1;
        irq_in = 4'b0010;
        tick();
        id_rd  = 1'b0;
        irq_in = 4'b0000;
        check("coll_pend", 32'(pend_out), 32'h2);
        check("coll_intr_lo", 32'(intr), 32'd0);
        tick();
        check("coll_intr_again", 32'(intr), 32'd1);
        service("coll2", 8'h81);
        check("coll_pend_clr", 32'(pend_out), 32'h0);

        // Held level on source 0 gives exactly one event.
        irq_in = 4'b0001;
        wait_intr("held_wait");
        service("held", 8'h80);
        high_cnt = 0;
        for (int i = 0; i < 44; i++) begin
            tick();
            if (intr) high_cnt++;
        end
        check("held_no_repeat", high_cnt, 32'd0);
        check("held_pend", 32'(pend_out), 32'h0);
        irq_in = 4'b0000;
        tick();

        // Asynchronous reset in REQ with pending 0110 and a modified mask.
        write_en(8'h05);
        irq_in = 4'b0110;
        tick();
        irq_in = 4'b0000;
        wait_intr("rst_wait");
        check("rst_pre_pend", 32'(pend_out), 32'h6);
        #2;
        rst = 1'b1;
        #1;
        check("arst_intr", 32'(intr), 32'd0);
        check("arst_pend", 32'(pend_out), 32'h0);
        check("arst_en", 32'(en_out), 32'hF);
        check("arst_id", 32'(id_out), 32'h00);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_pend", 32'(pend_out), 32'h0);
        check("post_rst_en", 32'(en_out), 32'hF);
        check("post_rst_id", 32'(id_out), 32'h00);
        check("post_rst_intr", 32'(intr), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
